simple_dual_ram_clr: RTL and testbench

SIMPLE_DUAL_RAM_CLR -- requirements
Module: simple_dual_ram_clr

---
 rtl/simple_dual_ram_clr.sv | 147 ++++++++++++++
 tb/tb_simple_dual_ram_clr.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_ram_clr.sv
// Simple dual-port RAM (one write, one read port) with a self-clearing sequence
// that fills every entry with INIT_VALUE after reset or on a clear pulse.
module simple_dual_ram_clr #(
    parameter int unsigned     SIZE       = 8,
    parameter int unsigned     DEPTH      = 8,
    parameter int unsigned     OUT_REG    = 0,
    parameter int unsigned     RDW_MODE   = 0,
    parameter logic [SIZE-1:0] INIT_VALUE = '0,
    localparam int unsigned    AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] write_data,
    input  logic            write_en,
    input  logic [AW-1:0]   raddr,
    input  logic            read_en,
    input  logic            clear,
    output logic [SIZE-1:0] read_data,
    output logic            read_valid,
    output logic            busy
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [AW-1:0]   ccnt;
    logic [AW-1:0]   ccnt_nxt;
    logic            busy_nxt;

    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [SIZE-1:0] mem_wd;
    logic            rd_acc;
    logic            wr_ok;
    logic            rd_ok;
    logic            rdw_hit;

    logic [SIZE-1:0] mem [DEPTH];
    logic            v1;
    logic [SIZE-1:0] d1;

    // Address range qualification (DEPTH need not be a power of two)
    assign wr_ok   = 32'(waddr) < DEPTH;
    assign rd_ok   = 32'(raddr) < DEPTH;
    assign rdw_hit = (RDW_MODE != 0) && write_en && wr_ok && (waddr == raddr);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            ccnt  <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            ccnt  <= ccnt_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic and write-port mux (clear path vs user path)
    always_comb begin
        state_nxt = state;
        ccnt_nxt  = ccnt;
        mem_we    = 1'b0;
        mem_wa    = waddr;
        mem_wd    = write_data;
        rd_acc    = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = ccnt;
                mem_wd = INIT_VALUE;
                if (clear) begin
                    ccnt_nxt = '0;
                end else if (ccnt == LAST) begin
                    state_nxt = ST_RUN;
                    ccnt_nxt  = '0;
                end else begin
                    ccnt_nxt = ccnt + AW'(1);
                end
            end
            default: begin
                mem_we = write_en && wr_ok;
                rd_acc = read_en;
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    ccnt_nxt  = '0;
                end
            end
        endcase
        busy_nxt = (state_nxt == ST_CLEAR);
    end

    // Storage array: no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read port; data register holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                if (!rd_ok) begin
                    d1 <= INIT_VALUE;
                end else if (rdw_hit) begin
                    d1 <= write_data;
                end else begin
                    d1 <= mem[raddr];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic            v2;
        logic [SIZE-1:0] d2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                end
            end
        end

        assign read_valid = v2;
        assign read_data  = d2;
    end else begin : g_no_out_reg
        assign read_valid = v1;
        assign read_data  = d1;
    end

endmodule

// File: tb/tb_simple_dual_ram_clr.sv
// Randomized bench for simple_dual_ram_clr: three configurations driven in
// lockstep and compared every cycle against a behavioural memory model.
module tb_simple_dual_ram_clr;

    localparam logic [7:0] INIT = 8'hA5;

    logic       clk;
    logic       rst;
    logic [3:0] waddr;
    logic [7:0] write_data;
    logic       write_en;
    logic [3:0] raddr;
    logic       read_en;
    logic       clear;
    logic [7:0] rd [3];
    logic       rv [3];
    logic       bz [3];

    int n_vec;
    int n_err;
    int bcnt;
    int bcnt_c;

    // Model state
    logic [7:0] mm [3][16];
    int         left [3];
    logic       pv [3];
    logic [7:0] pd [3];
    logic [7:0] last [3];
    logic       ev [3];

    simple_dual_ram_clr #(.SIZE(8), .DEPTH(16), .OUT_REG(0), .RDW_MODE(0), .INIT_VALUE(INIT)) u_a (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .clear(clear),
        .read_data(rd[0]), .read_valid(rv[0]), .busy(bz[0]));

    simple_dual_ram_clr #(.SIZE(8), .DEPTH(16), .OUT_REG(1), .RDW_MODE(1), .INIT_VALUE(INIT)) u_b (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .clear(clear),
        .read_data(rd[1]), .read_valid(rv[1]), .busy(bz[1]));

    simple_dual_ram_clr #(.SIZE(8), .DEPTH(10), .OUT_REG(1), .RDW_MODE(0), .INIT_VALUE(INIT)) u_c (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .clear(clear),
        .read_data(rd[2]), .read_valid(rv[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int i);
        return (i == 2) ? 10 : 16;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic bit rdw(input int i);
        return i == 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            left[i] = dep(i);
            pv[i]   = 1'b0;
            pd[i]   = 8'h00;
            last[i] = 8'h00;
            ev[i]   = 1'b0;
        end
    endtask

    // One clock edge of the reference behaviour for configuration i
    task automatic model_edge(input int i, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic re, input logic [3:0] ra, input logic clr);
        int         d;
        logic       nv;
        logic [7:0] nd;
        logic       vv;
        logic [7:0] vd;
        d  = dep(i);
        nv = 1'b0;
        nd = 8'h00;
        if (left[i] > 0) begin
            mm[i][d - left[i]] = INIT;
            left[i] = clr ? d : left[i] - 1;
        end else begin
            if (re) begin
                nv = 1'b1;
                if (int'(ra) >= d)                    nd = INIT;
                else if (rdw(i) && we && wa == ra)    nd = wd;
                else                                  nd = mm[i][ra];
            end
            if (we && int'(wa) < d) mm[i][wa] = wd;
            if (clr) left[i] = d;
        end
        if (lat(i) == 1) begin
            vv    = pv[i];
            vd    = pd[i];
            pv[i] = nv;
            pd[i] = nd;
        end else begin
            vv = nv;
            vd = nd;
        end
        if (vv) last[i] = vd;
        ev[i] = vv;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(left[i] > 0));
            chk($sformatf("rvalid%0d", i), 32'(rv[i]), 32'(ev[i]));
            chk($sformatf("rdata%0d", i), 32'(rd[i]), 32'(last[i]));
        end
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic re, input logic [3:0] ra, input logic clr);
        write_en   = we;
        waddr      = wa;
        write_data = wd;
        read_en    = re;
        raddr      = ra;
        clear      = clr;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, we, wa, wd, re, ra, clr);
        #1;
        check_all();
        if (bz[0]) bcnt++;
        if (bz[2]) bcnt_c++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rand_step(input logic clr);
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), clr);
    endtask

    // Wait out a clear sequence on the slowest instance, bounded
    task automatic wait_clear(input string tag, input int exp_len);
        int guard;
        guard = 0;
        while ((bz[0] || bz[1]) && guard < 100) begin
            idle(1);
            guard++;
        end
        chk(tag, 32'(bcnt), 32'(exp_len));
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), 32'(bz[i]), 32'd1);
            chk($sformatf("%s_rvalid%0d", tag, i), 32'(rv[i]), 32'd0);
            chk($sformatf("%s_rdata%0d", tag, i), 32'(rd[i]), 32'd0);
        end
        model_reset();
        write_en = 1'b0;
        read_en  = 1'b0;
        clear    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst  = 1'b0;
        bcnt = 1;
        bcnt_c = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        write_en   = 1'b0;
        waddr      = 4'd0;
        write_data = 8'h00;
        read_en    = 1'b0;
        raddr      = 4'd0;
        clear      = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'd1);
            chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), 32'(rd[i]), 32'd0);
        end
        rst    = 1'b0;
        bcnt   = 1;
        bcnt_c = 1;
        wait_clear("init_busy_len", 16);
        chk("init_busy_len_d10", 32'(bcnt_c), 32'd10);

        // Every entry reads back the clear value
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
        idle(2);

        // Write then read, then same-address read-during-write
        step(1'b1, 4'd7, 8'h3C, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd7, 8'h55, 1'b1, 4'd7, 1'b0);
        idle(2);
        chk("rdw_old_data", 32'(rd[0]), 32'h3C);
        chk("rdw_new_data", 32'(rd[1]), 32'h55);

        // Fill with address pattern, then stream reads
        for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 8'(a), 1'b0, 4'd0, 1'b0);
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
        idle(2);

        // Random traffic with occasional clears
        for (int k = 0; k < 400; k++) rand_step(1'($urandom_range(0, 39) == 0));
        idle(20);

        // Clear with a restart at the fifth busy cycle; writes while busy ignored
        for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 8'($urandom), 1'b0, 4'd0, 1'b0);
        bcnt   = 0;
        bcnt_c = 0;
        step(1'b1, 4'd2, 8'h77, 1'b1, 4'd3, 1'b1);
        for (int k = 0; k < 4; k++) rand_step(1'b0);
        rand_step(1'b1);
        begin
            int guard;
            guard = 0;
            while ((bz[0] || bz[1]) && guard < 100) begin
                rand_step(1'b0);
                guard++;
            end
        end
        chk("clr_restart_busy_len", 32'(bcnt), 32'd21);
        chk("clr_restart_busy_len_d10", 32'(bcnt_c), 32'd15);
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
        idle(2);

        // Out-of-range write and read on the 10-entry instance
        step(1'b1, 4'd12, 8'hFF, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd12, 1'b0);
        idle(2);
        chk("oor_read_d10", 32'(rd[2]), 32'hA5);
        for (int a = 0; a < 10; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
        idle(2);

        // Reset during a read burst
        for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 8'(8'h40 + a), 1'b0, 4'd0, 1'b0);
        for (int a = 0; a < 5; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a + 3), 1'b0);
        read_en = 1'b1;
        do_reset("rst_burst");
        wait_clear("rst_burst_busy_len", 16);

        // Reset at clear cycle 8
        do_reset("rst_pre");
        wait_clear("rst_pre_busy_len", 16);
        step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
        idle(8);
        do_reset("rst_mid_clear");
        wait_clear("rst_mid_clear_busy_len", 16);
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
